// File: rtl/sr_pattern_serializer.sv
// rtl/sr_pattern_serializer.sv - ROM-backed word serializer with divided word clock
// Optional: define SR_LSB_FIRST_EN to send each word LSB-first instead of MSB-first.

module sr_pattern_serializer #(
  parameter int DIV    = 4,
  parameter int ADDR_W = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  output logic sr_out,
  output logic clk_4
);

  localparam int              CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int              DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2);

  logic [DIV-1:0]    rom [DEPTH];

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DIV-1:0]    rd_data_q;
  logic [DIV-1:0]    shreg_q, shreg_d;
  logic              sr_q, sr_d;
  logic              clk4_q, clk4_d;
  logic              load;

  // Each word is its own address truncated or zero-extended to DIV bits.
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = DIV'(g);
  end

  always_comb begin
    load      = (bit_cnt_q == LAST);
    bit_cnt_d = load ? '0 : bit_cnt_q + CNT_W'(1);
    addr_d    = load ? addr_q + ADDR_W'(1) : addr_q;
    shreg_d   = shreg_q;
    if (load) begin
      shreg_d = rd_data_q;
    end else begin
`ifdef SR_LSB_FIRST_EN
      shreg_d = shreg_q >> 1;
`else
      shreg_d = shreg_q << 1;
`endif
    end
`ifdef SR_LSB_FIRST_EN
    sr_d = shreg_d[0];
`else
    sr_d = shreg_d[DIV-1];
`endif
    // High for the first half of each word, so it rises together with the load.
    clk4_d = (bit_cnt_d < HALF);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bit_cnt_q <= '0;
      addr_q    <= '0;
      rd_data_q <= '0;
      shreg_q   <= '0;
      sr_q      <= 1'b0;
      clk4_q    <= 1'b1;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      rd_data_q <= rom[addr_q];
      shreg_q   <= shreg_d;
      sr_q      <= sr_d;
      clk4_q    <= clk4_d;
    end
  end

  assign sr_out = sr_q;
  assign clk_4  = clk4_q;

endmodule

// File: tb/tb_sr_pattern_serializer.sv
// tb/tb_sr_pattern_serializer.sv - directed checks of serial data and word clock

module tb_sr_pattern_serializer;

  logic clk_in;
  logic rst_n_in;
  logic sr_out;
  logic clk_4;

  int total;
  int bad;

  sr_pattern_serializer #(.DIV(4), .ADDR_W(4)) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .sr_out  (sr_out),
    .clk_4   (clk_4)
  );

  initial clk_in = 1'b0;
  always #10 clk_in = ~clk_in;

  // Expected sr_out after edges 1..15 from release.
`ifdef SR_LSB_FIRST_EN
  logic [15:0] first_exp = 16'b0_000_0000_1000_0100;
  logic [11:0] wrap_exp  = 12'b1111_0000_1000;
`else
  logic [15:0] first_exp = 16'b0_000_0000_0001_0010;
  logic [11:0] wrap_exp  = 12'b1111_0000_0001;
`endif

  task automatic release_reset();
    rst_n_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      total++;
      if (sr_out !== 1'b0) begin
        bad++;
        $display("FAIL reset_sr cycle %0d: got %b want 0", i, sr_out);
      end
      total++;
      if (clk_4 !== 1'b1) begin
        bad++;
        $display("FAIL reset_clk4 cycle %0d: got %b want 1", i, clk_4);
      end
    end
  endtask

  // Assumes reset was just released at a falling edge.
  task automatic check_first_words(input string tag);
    logic exp_bit;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk_in);
      exp_bit = first_exp[15-k];
      total++;
      if (sr_out !== exp_bit) begin
        bad++;
        $display("FAIL %s edge %0d: sr_out got %b want %b", tag, k, sr_out, exp_bit);
      end
    end
  endtask

  task automatic test_first_words();
    release_reset();
    check_first_words("first_words");
  endtask

  task automatic test_clk_4();
    logic exp_clk;
    release_reset();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk_in);
      exp_clk = ((k % 4) < 2);
      total++;
      if (clk_4 !== exp_clk) begin
        bad++;
        $display("FAIL clk_4 edge %0d: got %b want %b", k, clk_4, exp_clk);
      end
    end
  endtask

  task automatic test_wrap();
    logic exp_bit;
    release_reset();
    for (int k = 1; k <= 75; k++) begin
      @(negedge clk_in);
      if (k >= 64) begin
        exp_bit = wrap_exp[75-k];
        total++;
        if (sr_out !== exp_bit) begin
          bad++;
          $display("FAIL wrap edge %0d: sr_out got %b want %b", k, sr_out, exp_bit);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    release_reset();
    for (int k = 1; k <= 30; k++) @(negedge clk_in);
    // Edge 30 is mid-word 6 (0110): sr_out=1, clk_4=0 before the reset pulse.
    total++;
    if (sr_out !== 1'b1 || clk_4 !== 1'b0) begin
      bad++;
      $display("FAIL mid_pre edge 30: sr_out=%b clk_4=%b want 1/0", sr_out, clk_4);
    end
    #3 rst_n_in = 1'b0;
    #1;
    total++;
    if (sr_out !== 1'b0) begin
      bad++;
      $display("FAIL mid_async_sr: got %b want 0", sr_out);
    end
    total++;
    if (clk_4 !== 1'b1) begin
      bad++;
      $display("FAIL mid_async_clk4: got %b want 1", clk_4);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    total++;
    if (sr_out !== 1'b0 || clk_4 !== 1'b1) begin
      bad++;
      $display("FAIL mid_hold: sr_out=%b clk_4=%b want 0/1", sr_out, clk_4);
    end
    rst_n_in = 1'b1;
    check_first_words("mid_restart");
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n_in = 1'b0;
    test_reset();
    test_first_words();
    test_clk_4();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_pattern_serializer.md
Name:
sr_pattern_serializer

Overview:
- BRAM-backed pattern serializer for the DTC tester front end.
- An internal pattern memory holds DIV-bit words. Words are read sequentially and shifted out one bit per clk_in cycle on sr_out.
- clk_4 is a divided word clock (clk_in / DIV) that rises on the first bit of each word.
- Sits between the board clock and downstream link/capture logic as a deterministic bit-pattern source.

Parameters:
- DIV, 4, serialization ratio. Equals word width in bits and the clk_in cycles per word. Must be even and ≥2.
- ADDR_W, 4, pattern memory address width. Depth is 2^ADDR_W words.

Ports:
- clk_in  input  1  single system clock; all logic on its rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- sr_out  output  1  serial data, registered.
- clk_4  output  1  divided word clock, registered, 50% duty, period DIV clk_in cycles.

Behaviour:
- Interface: one clock (clk_in); reset is asynchronous and active-low (rst_n_in). Every register clears immediately on rst_n_in low. Release is sampled on the next clk_in rising edge.
- Reset values:
  - bit_cnt=0, addr=0, rd_data=0, shreg=0
  - sr_out=0, clk_4=1
- Pattern memory: mem[a] = a mod 2^DIV, zero-extended when DIV > ADDR_W. Contents are fixed at initialisation and inferred as block RAM/ROM.
- Memory read is synchronous: rd_data <= mem[addr] every cycle (1-cycle latency).
- Counting: bit_cnt increments every cycle and wraps from DIV-1 to 0. Let edge k be the k-th rising edge after release; after edge k, bit_cnt = k mod DIV.
- Word load/advance: on an edge where bit_cnt==DIV-1:
  - shreg <= rd_data
  - addr <= addr+1; addr wraps from 2^ADDR_W-1 to 0.
  - addr is stable for ≥2 cycles before each load, so rd_data always holds mem[addr].
- Shift: on all other edges, shreg shifts left by one with zero fill. sr_out = shreg[DIV-1] (MSB-first).
- First data:
  - sr_out=0 after edges 1..DIV-1.
  - Word 0 occupies edges DIV..2DIV-1, word 1 occupies edges 2DIV..3DIV-1, and so on.
- Word clock: clk_4 <= (next bit_cnt < DIV/2). clk_4 is high while bit_cnt ∈ [0, DIV/2-1], so its rising edge coincides with each word load.
- Wrap-around: after word 2^ADDR_W-1, word 0 follows with no gap or duplicate.
- Reset mid-operation: all state returns to reset values at once. Sequence restarts from word 0 with the DIV-cycle zero prefix.
- No handshake; output is free-running.

Optional Feature:
- Macro SR_LSB_FIRST_EN.
- Defined:
  - Loaded word is shifted right.
  - sr_out = shreg[0], so the word is sent LSB-first.
  - Timing and clk_4 are unchanged.
- Undefined: MSB-first as specified above.

Test Plan:
- Reset (DIV=4, ADDR_W=4, 20 ns clk_in): hold rst_n_in=0 for 5 cycles -> sr_out=0, clk_4=1 throughout. Asserting rst_n_in low between edges clears the outputs without a clock edge.
- First words: release reset -> sr_out=0 after edges 1-3 and edges 4-7 (word 0 = 0000). After edges 8-11: 0,0,0,1 (word 1). After edges 12-15: 0,0,1,0.
- Word clock: after release -> clk_4 is 1 after edges 4k and 4k+1, 0 after edges 4k+2 and 4k+3. Period 80 ns, rising with every word load.
- Wrap: run to word 15 -> sr_out=1,1,1,1 after edges 64-67, then 0,0,0,0 after edges 68-71 (word 0). Word 1 follows at edges 72-75.
- Mid-operation reset: pulse rst_n_in low at edge 30 for 2 cycles -> sr_out=0 and clk_4=1 immediately. After release, the sequence matches the first-words scenario exactly.
- SR_LSB_FIRST_EN defined, DIV=4 -> word 1 appears as 1,0,0,0 after edges 8-11, and word 2 as 0,1,0,0.
